// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
// Holds the two-bit operation encodings used on the mode port.
package shift_reg_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;  // keep contents
    localparam mode_t MODE_SHR  = 2'b01;  // shift toward LSB, sdi_r enters MSB
    localparam mode_t MODE_SHL  = 2'b10;  // shift toward MSB, sdi_l enters LSB
    localparam mode_t MODE_LOAD = 2'b11;  // parallel load from pdi

endpackage : shift_reg_pkg

// File: rtl/shift_bit_counter.sv
// Counts shifts within a WIDTH-bit word and pulses word_done for one cycle
// after the shift that completes the word.
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   inc        - a shift happens on this edge
//   clr        - restart the word (parallel load); wins over inc
//   shift_cnt  - shifts since last load/reset/word boundary
//   word_done  - registered one-cycle completion pulse
module shift_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     inc,
    input  logic                     clr,
    output logic [$clog2(WIDTH)-1:0] shift_cnt,
    output logic                     word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          word_done_q;
    logic          word_done_d;

    // Next count and completion pulse; clear dominates so a load on the
    // last shift position suppresses the pulse.
    always_comb begin
        cnt_d       = cnt_q;
        word_done_d = 1'b0;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (inc) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d       = {CW{1'b0}};
                word_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= {CW{1'b0}};
            word_done_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
        end
    end

    assign shift_cnt = cnt_q;
    assign word_done = word_done_q;

endmodule : shift_bit_counter

// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with a per-word shift counter and word-complete pulse.
// Ports:
//   clk, reset_n     - clock (rising edge) and asynchronous active-low reset
//   en               - operation enable; when low everything holds
//   mode             - 00 hold, 01 shift right, 10 shift left, 11 load
//   sdi_r / sdi_l    - serial in at MSB (right shift) / LSB (left shift)
//   pdi              - parallel load data
//   pdo              - register contents
//   sdo_r / sdo_l    - combinational taps of pdo[0] / pdo[WIDTH-1]
//   shift_cnt        - shifts since last load, reset or word boundary
//   word_done        - one-cycle pulse after WIDTH shifts
module shift_reg_universal
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic                     sdi_r,
    input  logic                     sdi_l,
    input  logic [WIDTH-1:0]         pdi,
    output logic [WIDTH-1:0]         pdo,
    output logic                     sdo_r,
    output logic                     sdo_l,
    output logic [$clog2(WIDTH)-1:0] shift_cnt,
    output logic                     word_done
);

    logic [WIDTH-1:0] pdo_q;
    logic [WIDTH-1:0] pdo_d;
    logic             inc_s;
    logic             clr_s;

    // Decode which counter action this cycle's operation implies.
    always_comb begin
        inc_s = 1'b0;
        clr_s = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHR:  inc_s = 1'b1;
                MODE_SHL:  inc_s = 1'b1;
                MODE_LOAD: clr_s = 1'b1;
                MODE_HOLD: inc_s = 1'b0;
                default:   inc_s = 1'b0;
            endcase
        end else begin
            inc_s = 1'b0;
        end
    end

    // Next register contents.
    always_comb begin
        pdo_d = pdo_q;
        if (en) begin
            case (mode)
                MODE_SHR:  pdo_d = {sdi_r, pdo_q[WIDTH-1:1]};
                MODE_SHL:  pdo_d = {pdo_q[WIDTH-2:0], sdi_l};
                MODE_LOAD: pdo_d = pdi;
                MODE_HOLD: pdo_d = pdo_q;
                default:   pdo_d = pdo_q;
            endcase
        end else begin
            pdo_d = pdo_q;
        end
    end

    // Data register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pdo_q <= RESET_VALUE;
        end else begin
            pdo_q <= pdo_d;
        end
    end

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .inc       (inc_s),
        .clr       (clr_s),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    assign pdo   = pdo_q;
    assign sdo_r = pdo_q[0];
    assign sdo_l = pdo_q[WIDTH-1];

endmodule : shift_reg_universal

// File: tb/tb_shift_reg_universal.sv
module tb_shift_reg_universal;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         en;
    logic [1:0]   mode;
    logic         sdi_r;
    logic         sdi_l;
    logic [W-1:0] pdi;
    logic [W-1:0] pdo;
    logic         sdo_r;
    logic         sdo_l;
    logic [2:0]   shift_cnt;
    logic         word_done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: contents, shifts taken in the current word,
    // and whether the last edge completed a word.
    int unsigned m_val;
    int          m_shifts;
    bit          m_done;
    int          wd_pulses;

    shift_reg_universal #(
        .WIDTH       (W),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .mode      (mode),
        .sdi_r     (sdi_r),
        .sdi_l     (sdi_l),
        .pdi       (pdi),
        .pdo       (pdo),
        .sdo_r     (sdo_r),
        .sdo_l     (sdo_l),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pdo"},   {24'd0, pdo}, m_val);
        check({tag, ".sdo_r"}, {31'd0, sdo_r}, m_val % 2);
        check({tag, ".sdo_l"}, {31'd0, sdo_l}, (m_val / 128) % 2);
        check({tag, ".cnt"},   {29'd0, shift_cnt}, m_shifts);
        check({tag, ".wd"},    {31'd0, word_done}, {31'd0, m_done});
    endtask

    task automatic model_reset();
        m_val    = 0;
        m_shifts = 0;
        m_done   = 1'b0;
    endtask

    // Apply one cycle of stimulus, advance the model with arithmetic rules,
    // then compare one time unit after the edge.
    task automatic apply(input logic e, input logic [1:0] m, input logic sr,
                         input logic sl, input logic [7:0] p, input string tag);
        en = e; mode = m; sdi_r = sr; sdi_l = sl; pdi = p;
        @(posedge clk);
        m_done = 1'b0;
        if (e) begin
            if (m == 2'd1 || m == 2'd2) begin
                if (m == 2'd1) m_val = (m_val / 2) + (sr ? 128 : 0);
                else           m_val = ((m_val * 2) % 256) + (sl ? 1 : 0);
                m_shifts = m_shifts + 1;
                if (m_shifts == W) begin
                    m_shifts = 0;
                    m_done   = 1'b1;
                end
            end else if (m == 2'd3) begin
                m_val    = p;
                m_shifts = 0;
            end
        end
        #1;
        if (word_done === 1'b1) wd_pulses++;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] exp_sdo;
        logic [7:0] sl_seq;
        logic [7:0] saved_pdo;
        logic [2:0] saved_cnt;
        exp_sdo = 8'b1010_0101;   // bit i = expected sdo_r before shift i
        sl_seq  = 8'b1100_1011;   // bit 7 first
        reset_n = 1'b0; en = 1'b0; mode = 2'b00; sdi_r = 1'b0; sdi_l = 1'b0; pdi = 8'h00;
        model_reset();
        wd_pulses = 0;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // First edge after reset release must act.
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h5A, "first_load");

        // Mid-word asynchronous reset.
        repeat (3) apply(1'b1, 2'b01, 1'b1, 1'b0, 8'h00, "pre_rst_shift");
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst.pdo", {24'd0, pdo}, 32'h0);
        check("async_rst.cnt", {29'd0, shift_cnt}, 32'h0);
        check("async_rst.wd",  {31'd0, word_done}, 32'h0);
        #2 reset_n = 1'b1;

        // Load A5 then 8 right shifts of zero.
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5, "ld_a5");
        wd_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            check("shr_sdo_seq", {31'd0, sdo_r}, {31'd0, exp_sdo[i]});
            apply(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, "shr");
            if (i < 7) check("shr_no_wd", {31'd0, word_done}, 32'h0);
        end
        check("shr_final_pdo", {24'd0, pdo}, 32'h00);
        check("shr_wd_after8", {31'd0, word_done}, 32'h1);
        check("shr_wd_count", wd_pulses, 32'd1);

        // 8 left shifts building CB.
        wd_pulses = 0;
        for (int i = 7; i >= 0; i--) apply(1'b1, 2'b10, 1'b0, sl_seq[i], 8'h00, "shl");
        check("shl_final_pdo", {24'd0, pdo}, 32'hCB);
        check("shl_wd_count", wd_pulses, 32'd1);
        apply(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, "post_shl_hold");

        // Disabled load is ignored.
        saved_pdo = pdo; saved_cnt = shift_cnt;
        repeat (4) apply(1'b0, 2'b11, 1'b0, 1'b0, 8'hFF, "en0_load");
        check("en0_pdo", {24'd0, pdo}, 32'hCB);
        check("en0_cnt", {29'd0, shift_cnt}, 32'h0);

        // Load mid-word restarts the count.
        wd_pulses = 0;
        repeat (3) apply(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, "pre_ld");
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C, "ld_3c");
        repeat (7) apply(1'b1, 2'b01, 1'b1, 1'b0, 8'h00, "post_ld");
        check("ld_cnt7", {29'd0, shift_cnt}, 32'd7);
        check("ld_no_wd", wd_pulses, 32'd0);
        // Load exactly at the last position suppresses the pulse.
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h81, "ld_at_last");
        check("ld_last_wd", {31'd0, word_done}, 32'h0);
        repeat (7) apply(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, "post_ld2");
        apply(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, "eighth");
        check("ld_eighth_wd", {31'd0, word_done}, 32'h1);

        // Hold then mixed-direction shifts.
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h96, "ld_96");
        repeat (5) apply(1'b1, 2'b00, 1'b1, 1'b1, 8'hFF, "hold");
        check("hold_pdo", {24'd0, pdo}, 32'h96);
        wd_pulses = 0;
        for (int i = 0; i < 8; i++)
            apply(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0, 8'h00, "mixed");
        check("mixed_wd", {31'd0, word_done}, 32'h1);
        check("mixed_wd_count", wd_pulses, 32'd1);

        // Randomized operation against the model, with occasional async reset.
        for (int i = 0; i < 400; i++) begin
            logic e;
            logic [1:0] m;
            e = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 9))
                0:       m = 2'b11;
                1:       m = 2'b00;
                2, 3, 4: m = 2'b10;
                default: m = 2'b01;
            endcase
            apply(e, m, 1'($urandom), 1'($urandom), 8'($urandom), "rand");
            if ($urandom_range(0, 63) == 0) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                check_all("rand_rst");
                #2 reset_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_shift_reg_universal
